// File: rtl/sys_stacker_stream.sv
// -----------------------------------------------------------------------------
// sys_stacker_stream
//
// Purpose:
//   Serialises a wide input word of NumOfNerves lanes into DepthOut narrower
//   output beats of OUT_WIDTH lanes each. A word is held in a single holding
//   register and replayed slice by slice under valid/ready handshaking on both
//   sides. The last slice of a word can be consumed in the same cycle that the
//   next word is loaded, so continuous streams run without bubbles.
//
// Parameters:
//   BitSize      bits per lane
//   NumOfNerves  input lanes per word (must be divisible by DepthOut)
//   DepthOut     output beats per input word (>= 1)
//   MsbFirst     1: highest lanes go out first, 0: lowest lanes go out first
//
// Ports:
//   clk        single clock, all state updates on the rising edge
//   res_n      asynchronous active-low reset
//   in_valid   input word present
//   in_ready   block can accept a word this cycle
//   in_start   marks the input word as the first of a frame
//   in_data    input lanes [NumOfNerves-1:0][BitSize-1:0]
//   out_valid  out_data holds a valid slice
//   out_ready  downstream accepts the slice
//   out_start  slice 0 of a word that was accepted with in_start = 1
//   out_last   final slice (index DepthOut-1) of the current word
//   out_index  slice number within the current word
//   out_data   current slice [OUT_WIDTH-1:0][BitSize-1:0]
//
// Within a slice the intra-slice order is always preserved: the highest lane
// of the selected group lands in out_data[OUT_WIDTH-1].
// -----------------------------------------------------------------------------
module sys_stacker_stream #(
    parameter int BitSize     = 8,
    parameter int NumOfNerves = 4,
    parameter int DepthOut    = 2,
    parameter int MsbFirst    = 1,
    localparam int OUT_WIDTH  = NumOfNerves / DepthOut,
    localparam int IDX_W      = (DepthOut > 1) ? $clog2(DepthOut) : 1
) (
    input  logic                                  clk,
    input  logic                                  res_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic                                  in_start,
    input  logic [NumOfNerves-1:0][BitSize-1:0]   in_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  out_start,
    output logic                                  out_last,
    output logic [IDX_W-1:0]                      out_index,
    output logic [OUT_WIDTH-1:0][BitSize-1:0]     out_data
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DepthOut - 1);

    typedef enum logic {
        IDLE,
        SERIAL
    } state_t;

    state_t                              state;
    logic [NumOfNerves-1:0][BitSize-1:0] hold_p0;
    logic [IDX_W-1:0]                    cnt_p0;
    logic                                start_p0;

    logic                                busy;
    logic                                at_last;
    logic                                in_xfer;
    logic                                out_xfer;
    logic [OUT_WIDTH-1:0][BitSize-1:0]   sel_slice;

    // Every slice of the held word is a fixed lane range, so each one is a
    // constant part-select; the counter then only drives a DepthOut:1 mux.
    logic [OUT_WIDTH-1:0][BitSize-1:0]   slices [DepthOut];

    for (genvar k = 0; k < DepthOut; k++) begin : g_slice
        localparam int BASE = (MsbFirst != 0) ? (NumOfNerves - (k + 1) * OUT_WIDTH)
                                              : (k * OUT_WIDTH);
        assign slices[k] = hold_p0[BASE +: OUT_WIDTH];
    end

    if (DepthOut == 1) begin : g_single
        assign sel_slice = slices[0];
    end else begin : g_multi
        assign sel_slice = slices[cnt_p0];
    end

    // Handshake decode
    assign busy     = (state == SERIAL);
    assign at_last  = busy && (cnt_p0 == LAST_IDX);
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = busy && out_ready;

    // While a word is held, a new one can only be taken as its last slice
    // leaves; this is what keeps back-to-back words bubble-free.
    assign in_ready  = !busy || (at_last && out_ready);

    // Outputs are forced to zero whenever nothing valid is presented.
    assign out_valid = busy;
    assign out_last  = at_last;
    assign out_start = busy && (cnt_p0 == '0) && start_p0;
    assign out_index = busy ? cnt_p0 : '0;
    assign out_data  = busy ? sel_slice : '0;

    // Stage p0: holding register, slice counter and captured frame flag
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state    <= IDLE;
            hold_p0  <= '0;
            cnt_p0   <= '0;
            start_p0 <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_xfer) begin
                        hold_p0  <= in_data;
                        start_p0 <= in_start;
                        cnt_p0   <= '0;
                        state    <= SERIAL;
                    end
                end
                SERIAL: begin
                    if (out_xfer) begin
                        if (!at_last) begin
                            cnt_p0 <= cnt_p0 + IDX_W'(1);
                        end else if (in_xfer) begin
                            hold_p0  <= in_data;
                            start_p0 <= in_start;
                            cnt_p0   <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sys_stacker_stream.sv
// -----------------------------------------------------------------------------
// Bench for sys_stacker_stream. Three instances share one input stream:
//   u0: DepthOut=2, MsbFirst=1   u1: DepthOut=2, MsbFirst=0   u2: DepthOut=1
// A queue-of-beats reference model predicts every output of every instance.
// -----------------------------------------------------------------------------
module tb_sys_stacker_stream;

    logic        clk = 1'b0;
    logic        res_n;
    logic        in_valid;
    logic        in_start;
    logic [3:0][7:0] in_data;
    logic        out_ready;

    logic        ir0, ov0, os0, ol0;
    logic [0:0]  oi0;
    logic [1:0][7:0] od0;
    logic        ir1, ov1, os1, ol1;
    logic [0:0]  oi1;
    logic [1:0][7:0] od1;
    logic        ir2, ov2, os2, ol2;
    logic [0:0]  oi2;
    logic [3:0][7:0] od2;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    sys_stacker_stream #(.BitSize(8), .NumOfNerves(4), .DepthOut(2), .MsbFirst(1)) u0 (
        .clk(clk), .res_n(res_n), .in_valid(in_valid), .in_ready(ir0),
        .in_start(in_start), .in_data(in_data), .out_valid(ov0), .out_ready(out_ready),
        .out_start(os0), .out_last(ol0), .out_index(oi0), .out_data(od0));

    sys_stacker_stream #(.BitSize(8), .NumOfNerves(4), .DepthOut(2), .MsbFirst(0)) u1 (
        .clk(clk), .res_n(res_n), .in_valid(in_valid), .in_ready(ir1),
        .in_start(in_start), .in_data(in_data), .out_valid(ov1), .out_ready(out_ready),
        .out_start(os1), .out_last(ol1), .out_index(oi1), .out_data(od1));

    sys_stacker_stream #(.BitSize(8), .NumOfNerves(4), .DepthOut(1), .MsbFirst(1)) u2 (
        .clk(clk), .res_n(res_n), .in_valid(in_valid), .in_ready(ir2),
        .in_start(in_start), .in_data(in_data), .out_valid(ov2), .out_ready(out_ready),
        .out_start(os2), .out_last(ol2), .out_index(oi2), .out_data(od2));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s got %0h want %0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] d;
        bit          s;
        bit          l;
        int          idx;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];
    beat_t q2[$];

    // Slice k of a 4-lane word, built straight from the lane-numbering rule.
    function automatic logic [31:0] slice_of(input logic [31:0] w, input int dout,
                                             input int msb, input int k);
        logic [31:0] r;
        int ow;
        int base;
        ow   = 4 / dout;
        base = (msb != 0) ? 4 - (k + 1) * ow : k * ow;
        r    = '0;
        for (int j = 0; j < ow; j++) r[j*8 +: 8] = w[(base + j)*8 +: 8];
        return r;
    endfunction

    task automatic model_dut(input int d, input int dout, input int msb,
                             input logic ov, input logic os, input logic ol,
                             input logic [31:0] oi, input logic [31:0] od, input logic ir);
        beat_t q[$];
        beat_t b;
        logic  exp_ir;
        bit    ixf;
        case (d)
            0:       q = q0;
            1:       q = q1;
            default: q = q2;
        endcase
        exp_ir = (q.size() == 0) || (q.size() == 1 && out_ready);
        check($sformatf("u%0d.in_ready", d), 32'(ir), 32'(exp_ir));
        if (q.size() == 0) begin
            check($sformatf("u%0d.out_valid", d), 32'(ov), 32'd0);
            check($sformatf("u%0d.out_data", d), od, 32'd0);
            check($sformatf("u%0d.flags", d), {29'd0, os, ol, oi[0]}, 32'd0);
        end else begin
            b = q[0];
            check($sformatf("u%0d.out_valid", d), 32'(ov), 32'd1);
            check($sformatf("u%0d.out_data", d), od, b.d);
            check($sformatf("u%0d.out_start", d), 32'(os), 32'(b.s));
            check($sformatf("u%0d.out_last", d), 32'(ol), 32'(b.l));
            check($sformatf("u%0d.out_index", d), oi, 32'(b.idx));
        end
        ixf = in_valid && exp_ir;
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (ixf) begin
            for (int k = 0; k < dout; k++) begin
                b.d   = slice_of(in_data, dout, msb, k);
                b.s   = (k == 0) && in_start;
                b.l   = (k == dout - 1);
                b.idx = k;
                q.push_back(b);
            end
        end
        case (d)
            0:       q0 = q;
            1:       q1 = q;
            default: q2 = q;
        endcase
    endtask

    task automatic model_step();
        model_dut(0, 2, 1, ov0, os0, ol0, 32'(oi0), 32'(od0), ir0);
        model_dut(1, 2, 0, ov1, os1, ol1, 32'(oi1), 32'(od1), ir1);
        model_dut(2, 1, 1, ov2, os2, ol2, 32'(oi2), 32'(od2), ir2);
    endtask

    task automatic drive(input logic iv, input logic is, input logic [31:0] d, input logic ordy);
        in_valid  = iv;
        in_start  = is;
        in_data   = d;
        out_ready = ordy;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        iv;
        logic        is;
        logic [31:0] din;
        logic        ordy;
        logic        ev;
        logic        es;
        logic        el;
        logic        ei;
        logic [31:0] ed0;
        logic [31:0] ed1;
        logic        eir;
    } vec_t;

    vec_t vt[18];

    initial begin
        // single word, then 3-cycle stall, then A,B,C stream
        vt[0]  = '{1'b1, 1'b1, 32'h44332211, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000, 32'h0000, 1'b1};
        vt[1]  = '{1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h4433, 32'h2211, 1'b0};
        vt[2]  = '{1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h2211, 32'h4433, 1'b1};
        vt[3]  = '{1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000, 32'h0000, 1'b1};
        vt[4]  = '{1'b1, 1'b0, 32'hDDCCBBAA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000, 32'h0000, 1'b1};
        vt[5]  = '{1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hDDCC, 32'hBBAA, 1'b0};
        vt[6]  = '{1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hDDCC, 32'hBBAA, 1'b0};
        vt[7]  = '{1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hDDCC, 32'hBBAA, 1'b0};
        vt[8]  = '{1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hDDCC, 32'hBBAA, 1'b0};
        vt[9]  = '{1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'hBBAA, 32'hDDCC, 1'b1};
        vt[10] = '{1'b1, 1'b1, 32'h04030201, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000, 32'h0000, 1'b1};
        vt[11] = '{1'b1, 1'b0, 32'h08070605, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0403, 32'h0201, 1'b0};
        vt[12] = '{1'b1, 1'b0, 32'h08070605, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0201, 32'h0403, 1'b1};
        vt[13] = '{1'b1, 1'b1, 32'h0C0B0A09, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0807, 32'h0605, 1'b0};
        vt[14] = '{1'b1, 1'b1, 32'h0C0B0A09, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0605, 32'h0807, 1'b1};
        vt[15] = '{1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0C0B, 32'h0A09, 1'b0};
        vt[16] = '{1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0A09, 32'h0C0B, 1'b1};
        vt[17] = '{1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000, 32'h0000, 1'b1};

        res_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        #2;
        check("reset.out_valid", {29'd0, ov0, ov1, ov2}, 32'd0);
        check("reset.in_ready", {29'd0, ir0, ir1, ir2}, 32'h7);
        check("reset.flags", {26'd0, os0, ol0, oi0, os2, ol2, oi2}, 32'd0);
        check("reset.out_data", 32'(od0) | 32'(od1) | 32'(od2), 32'd0);
        @(negedge clk);
        res_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            drive(vt[i].iv, vt[i].is, vt[i].din, vt[i].ordy);
            #1;
            check($sformatf("v%0d.valid", i), 32'(ov0), 32'(vt[i].ev));
            check($sformatf("v%0d.start", i), 32'(os0), 32'(vt[i].es));
            check($sformatf("v%0d.last", i), 32'(ol0), 32'(vt[i].el));
            check($sformatf("v%0d.index", i), 32'(oi0), 32'(vt[i].ei));
            check($sformatf("v%0d.data_msb", i), 32'(od0), vt[i].ed0);
            check($sformatf("v%0d.data_lsb", i), 32'(od1), vt[i].ed1);
            check($sformatf("v%0d.in_ready", i), 32'(ir0), 32'(vt[i].eir));
            model_step();
        end

        // reset in the middle of a word
        @(negedge clk);
        drive(1'b1, 1'b1, 32'h55667788, 1'b1);
        #1; model_step();
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        check("midrst.slice0", 32'(od0), 32'h5566);
        model_step();
        #2;
        res_n = 1'b0;
        #1;
        check("midrst.out_valid", {29'd0, ov0, ov1, ov2}, 32'd0);
        check("midrst.out_data", 32'(od0) | 32'(od1) | 32'(od2), 32'd0);
        check("midrst.flags", {26'd0, os0, ol0, oi0, os1, ol1, oi1}, 32'd0);
        check("midrst.in_ready", {29'd0, ir0, ir1, ir2}, 32'h7);
        q0.delete(); q1.delete(); q2.delete();
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        #1; model_step();
        @(negedge clk);
        res_n = 1'b1;
        drive(1'b1, 1'b0, 32'h99AABBCC, 1'b1);
        #1; model_step();
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        #1;
        check("postrst.index", {31'd0, oi0}, 32'd0);
        check("postrst.data", 32'(od0), 32'h99AA);
        check("postrst.whole", 32'(od2), 32'h99AABBCC);
        model_step();

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, $urandom,
                  $urandom_range(0, 9) < 7);
            #1;
            model_step();
        end

        // continuous streaming at full throughput
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            drive(1'b1, $urandom_range(0, 1) == 1, $urandom, 1'b1);
            #1;
            model_step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sys_stacker_stream.md
SYS_STACKER_STREAM -- requirements
Module: sys_stacker_stream

Interface
REQ-001 SHALL have parameter BitSize, default 8, meaning bits per lane.
REQ-002 SHALL have parameter NumOfNerves, default 4, meaning input lanes per word; must be divisible by DepthOut.
REQ-003 SHALL have parameter DepthOut, default 2, meaning output beats per input word (DepthOut >= 1).
REQ-004 SHALL have parameter MsbFirst, default 1, meaning 1 = highest lanes emitted first, 0 = lowest lanes first.
REQ-005 SHALL derive OUT_WIDTH = NumOfNerves/DepthOut and IDX_W = max(1, $clog2(DepthOut)).
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 res_n  input  1  reset is asynchronous and active-low.
REQ-008 in_valid  input  1  input word present.
REQ-009 in_ready  output  1  block can accept a word this cycle.
REQ-010 in_start  input  1  word is first of a frame; sampled with in_data.
REQ-011 in_data  input  [NumOfNerves-1:0][BitSize-1:0]  input lanes.
REQ-012 out_valid  output  1  out_data holds a valid slice.
REQ-013 out_ready  input  1  downstream accepts the slice.
REQ-014 out_start  output  1  slice 0 of a word accepted with in_start=1.
REQ-015 out_last  output  1  final slice (index DepthOut-1) of current word.
REQ-016 out_index  output  IDX_W  slice number within current word.
REQ-017 out_data  output  [OUT_WIDTH-1:0][BitSize-1:0]  current slice.

Function
REQ-018 Input transfer SHALL occur when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-019 State machine SHALL have states IDLE (holding register empty) and SERIAL (word held, slices pending).
REQ-020 IDLE: in_ready=1, out_valid=0; on input transfer SHALL load holding register, capture in_start, clear slice counter, go SERIAL.
REQ-021 SERIAL: out_valid=1; on output transfer with counter < DepthOut-1 SHALL increment counter, stay SERIAL.
REQ-022 SERIAL: in_ready SHALL equal out_last && out_ready (combinational), giving back-to-back words with no bubble.
REQ-023 On output transfer of last slice: if input transfer same cycle, SHALL load new word, counter to 0, stay SERIAL; else go IDLE.
REQ-024 Latency SHALL be 1 cycle: word accepted at edge N, slice 0 valid from edge N.
REQ-025 Slice k with MsbFirst=1 SHALL be lanes NumOfNerves-1-k*OUT_WIDTH down to NumOfNerves-(k+1)*OUT_WIDTH, highest lane in out_data[OUT_WIDTH-1].
REQ-026 Slice k with MsbFirst=0 SHALL be lanes (k+1)*OUT_WIDTH-1 down to k*OUT_WIDTH, same intra-slice order.
REQ-027 out_data, out_start, out_last, out_index SHALL stay stable while out_valid && !out_ready.
REQ-028 out_start SHALL be 1 only when out_valid, counter=0 and captured start=1; out_last only when out_valid and counter=DepthOut-1.
REQ-029 When out_valid=0, out_data SHALL be 0 and out_start, out_last, out_index SHALL be 0.
REQ-030 DepthOut=1 SHALL act as a one-deep registered pipe: out_last=1 and out_index=0 on every valid beat.
REQ-031 in_start on a word SHALL not truncate the word in progress; it only flags the new word.
REQ-032 Counter SHALL never exceed DepthOut-1; wrap to 0 only on new word load.

Reset
REQ-033 res_n low SHALL asynchronously force IDLE, counter 0, captured start 0, holding register 0.
REQ-034 During and after reset: out_valid=0, out_start=0, out_last=0, out_index=0, out_data=0, in_ready=1.
REQ-035 Reset mid-word SHALL discard remaining slices; first transfer after release starts a fresh word.

Verification (BitSize=8, NumOfNerves=4, DepthOut=2 unless noted)
REQ-036 Single word 0x44_33_22_11 (lane3..0), in_start=1, out_ready=1 -> cycle+0: {0x44,0x33} start=1 idx0; cycle+1: {0x22,0x11} last=1 idx1; then IDLE.
REQ-037 MsbFirst=0, same word -> {0x22,0x11} first, then {0x44,0x33} with last=1.
REQ-038 Stall: out_ready=0 for 3 cycles on slice 0 -> slice 0 held unchanged, in_ready=0; release -> slice 1 follows next cycle.
REQ-039 Streaming: in_valid=1 continuous, words A,B,C, out_ready=1 -> 6 consecutive valid slices, no bubble, in_ready pulses on each last slice.
REQ-040 Reset asserted after slice 0 of a word -> outputs zero immediately; after release, next word emits slice 0 with idx0.
REQ-041 DepthOut=1, NumOfNerves=4 -> each accepted word appears whole one edge later with out_last=1, full throughput.
